// File: rtl/dlx_pkg.sv
// Shared DLX definitions: datapath width, PC increment, NOP encoding and the
// fetch-buffer entry layout.
package dlx_pkg;

  localparam int          DLX_XLEN    = 32;
  localparam logic [31:0] DLX_PC_STEP = 32'd4;
  localparam logic [31:0] DLX_NOP     = 32'h0000_0000;

  typedef struct packed {
    logic [DLX_XLEN-1:0] inst;
    logic [DLX_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/dlx_fetch_fifo.sv
// Two-entry registered skid FIFO holding fetched {inst, pc} pairs for decode.
// Flush clears occupancy in one edge; the head is read straight from storage.
module dlx_fetch_fifo
  import dlx_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && count == 2'd2));

endmodule

// File: rtl/dlx_fetch_stage.sv
// DLX instruction-fetch stage: PC, 1-cycle synchronous ROM interface, 2-entry
// skid buffer to decode, redirect flush. Optional counters: DLX_FETCH_STATS_EN.
module dlx_fetch_stage
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = DLX_PC_STEP,
  parameter logic [31:0] NOP_INST = DLX_NOP
) (
  input  logic        clock_i,
  input  logic        reset_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_en_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_npc_o
`ifdef DLX_FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetch_o,
  output logic [31:0] stat_stall_o,
  output logic [31:0] stat_flush_o
`endif
);

  logic [31:0]  fetch_pc;
  logic         vld_p1;
  logic [31:0]  pc_p1;
  logic [31:0]  last_pc;
  logic [1:0]   count;
  logic [2:0]   occ;
  logic         pop;
  logic         push;
  logic         issue;
  fetch_entry_t head;
  fetch_entry_t din;

  assign pop   = id_valid_o & id_ready_i;
  assign occ   = {1'b0, count} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue = (occ < 3'd2);
  assign push  = vld_p1 & ~redirect_en_i;
  assign din   = '{inst: imem_data_i, pc: pc_p1};

  // Stage p0 -> p1: PC register drives the ROM address; redirect wins over issue.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      fetch_pc <= RESET_PC;
      vld_p1   <= 1'b0;
      last_pc  <= RESET_PC;
    end else begin
      if (redirect_en_i) begin
        fetch_pc <= redirect_pc_i;
        vld_p1   <= 1'b0;
      end else begin
        vld_p1 <= issue;
        if (issue) fetch_pc <= fetch_pc + PC_STEP;
      end
      if (id_valid_o) last_pc <= head.pc;
    end
  end

  always_ff @(posedge clock_i) begin
    if (issue) pc_p1 <= fetch_pc;
  end

  assign imem_addr_o = fetch_pc;

  // Stage p1 -> buffer: returning ROM word joins its PC in the skid FIFO.
  dlx_fetch_fifo u_fifo (
    .clk   (clock_i),
    .rst_n (reset_i),
    .push  (push),
    .pop   (pop),
    .flush (redirect_en_i),
    .din   (din),
    .count (count),
    .head  (head)
  );

  // Buffer -> decode: an empty buffer shows NOP and keeps the last PC visible.
  assign id_valid_o = (count != 2'd0);
  assign id_inst_o  = id_valid_o ? head.inst : NOP_INST;
  assign id_pc_o    = id_valid_o ? head.pc : last_pc;
  assign id_npc_o   = id_pc_o + PC_STEP;

`ifdef DLX_FETCH_STATS_EN
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      stat_fetch_o <= 32'd0;
      stat_stall_o <= 32'd0;
      stat_flush_o <= 32'd0;
    end else begin
      if (pop)                        stat_fetch_o <= stat_fetch_o + 32'd1;
      if (id_valid_o && !id_ready_i)  stat_stall_o <= stat_stall_o + 32'd1;
      if (redirect_en_i)              stat_flush_o <= stat_flush_o + 32'd1;
    end
  end
`endif

endmodule
